seq_mult8: RTL

Sequential 8×8 shift-and-add multiplier producing a 16-bit product over eight iterations. It sits directly downstream of the 8-bit ripple add/subtract datapath and is its consumer. Each cycle it drives one add (or subtract) of the multiplicand into a partial-product accumulator, captures sum and carry, and shifts. It replaces the unrolled array multiplier where area matters more than latency.

---
 rtl/seq_mult8.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/seq_mult8.sv
// seq_mult8 - sequential 8x8 shift-and-add multiplier, 16-bit product.
//
// One add of the multiplicand into a partial-product accumulator is made per
// cycle, followed by a right shift of {ACC,Q}. Eight steps give the product.
// This trades latency for a single adder in place of an array multiplier.
//
// Build option:
//   SEQ_MULT8_SIGNED_EN  defined   -> two's complement operands, radix-2 Booth
//                                     (9-bit add/subtract, Q_M1 register)
//                        undefined -> unsigned shift-add only
//
// Ports:
//   CLK    in   1   clock, rising edge
//   RST    in   1   synchronous active-high reset
//   START  in   1   request, accepted in IDLE or DONE only
//   A      in   8   multiplicand, captured on accept
//   B      in   8   multiplier, captured on accept
//   BUSY   out  1   high while the 8 steps are in progress
//   DONE   out  1   one-cycle pulse, P holds a new result
//   P      out  16  product register, held until the next completion
//
// state  | meaning
// -------+-------------------------------------------------
// S_IDLE | waiting for START, BUSY=0, DONE=0
// S_CALC | eight shift-add steps, CNT 0..7, BUSY=1
// S_DONE | result just written to P, DONE=1 for one cycle

module seq_mult8 (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic        BUSY,
    output logic        DONE,
    output logic [15:0] P
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [2:0]  cnt;
    logic [7:0]  mcand;
    logic [8:0]  acc;
    logic [7:0]  q;

    logic        accept;
    logic        last_step;

    logic [8:0]  addend;
    logic [8:0]  sum9;
    logic [8:0]  acc_nxt;
    logic [7:0]  q_nxt;

    assign accept    = START && ((state == S_IDLE) || (state == S_DONE));
    assign last_step = (state == S_CALC) && (cnt == 3'd7);

`ifdef SEQ_MULT8_SIGNED_EN
    logic q_m1;
    logic mode;
    logic cin;

    // Booth pair {Q[0],Q_M1}: 01 adds, 10 subtracts, 00/11 only shift.
    // MCAND is sign-extended to 9 bits so that -128 survives the subtract.
    always_comb begin
        mode   = q[0] & ~q_m1;
        addend = '0;
        cin    = 1'b0;
        if (q[0] ^ q_m1) begin
            addend = mode ? ~{mcand[7], mcand} : {mcand[7], mcand};
            cin    = mode;
        end
        sum9    = acc + addend + {8'd0, cin};
        acc_nxt = {sum9[8], sum9[8:1]};
        q_nxt   = {sum9[0], q[7:1]};
    end
`else
    // ACC[8] is always zero between steps, so the 9-bit sum carries the
    // 8-bit adder's carry-out in sum9[8] without overflow.
    always_comb begin
        addend  = q[0] ? {1'b0, mcand} : 9'd0;
        sum9    = acc + addend;
        acc_nxt = {1'b0, sum9[8:1]};
        q_nxt   = {sum9[0], q[7:1]};
    end
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        BUSY      = 1'b0;
        DONE      = 1'b0;
        case (state)
            S_IDLE: begin
                if (START) begin
                    state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                BUSY = 1'b1;
                if (cnt == 3'd7) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                DONE = 1'b1;
                if (START) begin
                    state_nxt = S_CALC;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // P is written only on the final step, so the previous result stays
    // readable for the whole CALC phase.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt   <= 3'd0;
            mcand <= 8'd0;
            acc   <= 9'd0;
            q     <= 8'd0;
            P     <= 16'h0000;
`ifdef SEQ_MULT8_SIGNED_EN
            q_m1  <= 1'b0;
`endif
        end else if (accept) begin
            cnt   <= 3'd0;
            mcand <= A;
            acc   <= 9'd0;
            q     <= B;
`ifdef SEQ_MULT8_SIGNED_EN
            q_m1  <= 1'b0;
`endif
        end else if (state == S_CALC) begin
            cnt   <= cnt + 3'd1;
            acc   <= acc_nxt;
            q     <= q_nxt;
`ifdef SEQ_MULT8_SIGNED_EN
            q_m1  <= q[0];
`endif
            if (last_step) begin
                P <= {acc_nxt[7:0], q_nxt};
            end
        end
    end

endmodule
